// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC result-path constants
//
// Purpose: widths and default sizes shared by the SAR control block and the
//          result buffer, so the result width is defined in one place.
// Ports:   none (package).
package adc_pkg;

  localparam int ADC_RESULT_BITS = 12;  // averaged result range 0..4095
  localparam int ADC_FIFO_DEPTH  = 8;   // power of two
  localparam int ADC_FIFO_ABITS  = 3;   // log2(ADC_FIFO_DEPTH)
  localparam int ADC_DROP_BITS   = 8;   // saturating drop counter width

endpackage

// File: rtl/adc_sync_fifo.sv
// rtl/adc_sync_fifo.sv - first-word-fall-through synchronous FIFO
//
// Purpose: stores conversion results; head entry is always presented on
//          rd_data with rd_valid asserted while the FIFO is non-empty.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            drop all entries (pointers/level to 0)
//   wr_en, wr_data   write request and data
//   wr_accept        write request is stored this cycle
//   rd_ready         consumer takes rd_data this cycle
//   rd_data          head-of-FIFO entry
//   rd_valid         FIFO non-empty (registered)
//   level            number of stored entries, 0..DEPTH
import adc_pkg::*;

module adc_sync_fifo #(
  parameter int WIDTH     = ADC_RESULT_BITS,
  parameter int DEPTH     = ADC_FIFO_DEPTH,
  parameter int ADDR_BITS = ADC_FIFO_ABITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 wr_accept,
  input  logic                 rd_ready,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  output logic [ADDR_BITS:0]   level
);

  localparam logic [ADDR_BITS:0] FULL_LEVEL = (ADDR_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   level_q;
  logic [ADDR_BITS:0]   level_next;
  logic                 valid_q;
  logic                 pop;
  logic                 full;

  assign full = (level_q == FULL_LEVEL);
  // Pop only qualifies on a non-empty FIFO, so ready while empty is harmless.
  assign pop  = valid_q & rd_ready & ~flush;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
  assign wr_accept = wr_en & ~flush & (~full | pop);

  always_comb begin
    level_next = level_q;
    if (wr_accept && !pop) begin
      level_next = level_q + 1'b1;
    end else if (pop && !wr_accept) begin
      level_next = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      // Cleared so the head output reads 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_accept) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level_q <= level_next;
      valid_q <= (level_next != '0);
    end
  end

  assign rd_data  = mem[rd_ptr];
  assign rd_valid = valid_q;
  assign level    = level_q;

endmodule

// File: rtl/adc_result_buffer.sv
// rtl/adc_result_buffer.sv - conversion result buffer with overflow and threshold irq
//
// Purpose: captures each result on conv_finished_strobe_in into an FWFT FIFO,
//          tracks dropped samples and pulses an interrupt on threshold hits.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   result_in                conversion result from the control block
//   conv_finished_strobe_in  one-cycle strobe, result_in valid in that cycle
//   flush_in                 synchronous FIFO flush
//   data_out/data_valid_out  head sample / FIFO non-empty
//   data_ready_in            consumer accepts data_out
//   fifo_level_out           stored entries, 0..DEPTH
//   overflow_out             sticky drop flag
//   overflow_clear_in        clears overflow_out and drop_count_out
//   drop_count_out           saturating dropped-sample count
//   threshold_in             unsigned compare level
//   threshold_irq_out        one-cycle pulse for an accepted sample >= threshold
import adc_pkg::*;

module adc_result_buffer #(
  parameter int RESULT_BITS = ADC_RESULT_BITS,
  parameter int DEPTH       = ADC_FIFO_DEPTH,
  parameter int ADDR_BITS   = ADC_FIFO_ABITS,
  parameter int DROP_BITS   = ADC_DROP_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RESULT_BITS-1:0] result_in,
  input  logic                   conv_finished_strobe_in,
  input  logic                   flush_in,
  output logic [RESULT_BITS-1:0] data_out,
  output logic                   data_valid_out,
  input  logic                   data_ready_in,
  output logic [ADDR_BITS:0]     fifo_level_out,
  output logic                   overflow_out,
  input  logic                   overflow_clear_in,
  output logic [DROP_BITS-1:0]   drop_count_out,
  input  logic [RESULT_BITS-1:0] threshold_in,
  output logic                   threshold_irq_out
);

  logic wr_accept;
  logic drop;

  adc_sync_fifo #(
    .WIDTH     (RESULT_BITS),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_in),
    .wr_en     (conv_finished_strobe_in),
    .wr_data   (result_in),
    .wr_accept (wr_accept),
    .rd_ready  (data_ready_in),
    .rd_data   (data_out),
    .rd_valid  (data_valid_out),
    .level     (fifo_level_out)
  );

  // A strobe discarded by flush is not a drop; only a full FIFO drops.
  assign drop = conv_finished_strobe_in & ~flush_in & ~wr_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_out      <= 1'b0;
      drop_count_out    <= '0;
      threshold_irq_out <= 1'b0;
    end else begin
      threshold_irq_out <= wr_accept && (result_in >= threshold_in);
      // A drop in the same cycle as a clear wins: the flag stays set and the
      // count restarts at one.
      if (drop) begin
        overflow_out <= 1'b1;
        if (overflow_clear_in) begin
          drop_count_out <= DROP_BITS'(1);
        end else if (!(&drop_count_out)) begin
          drop_count_out <= drop_count_out + 1'b1;
        end
      end else if (overflow_clear_in) begin
        overflow_out   <= 1'b0;
        drop_count_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adc_result_buffer.sv
// tb/tb_adc_result_buffer.sv - self-checking bench for adc_result_buffer
module tb_adc_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] result_in;
  logic        stb;
  logic        flush;
  logic [11:0] data_out;
  logic        data_valid;
  logic        ready;
  logic [3:0]  level;
  logic        ovf;
  logic        clr;
  logic [7:0]  drop_cnt;
  logic [11:0] thr;
  logic        irq;

  int total  = 0;
  int passed = 0;

  // Scoreboard: samples the bench expects to be stored, head first.
  int q[$];
  bit m_ovf;
  int m_cnt;
  bit m_irq;

  adc_result_buffer dut (
    .clk                     (clk),
    .rst                     (rst),
    .result_in               (result_in),
    .conv_finished_strobe_in (stb),
    .flush_in                (flush),
    .data_out                (data_out),
    .data_valid_out          (data_valid),
    .data_ready_in           (ready),
    .fifo_level_out          (level),
    .overflow_out            (ovf),
    .overflow_clear_in       (clr),
    .drop_count_out          (drop_cnt),
    .threshold_in            (thr),
    .threshold_irq_out       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Update the scoreboard from the inputs applied this cycle, clock the DUT,
  // then compare every output against the scoreboard.
  task automatic cyc();
    bit pop;
    bit acc;
    bit drp;
    pop = (q.size() != 0) && ready && !flush;
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_cnt = 0;
      m_irq = 0;
    end else begin
      acc = 0;
      drp = 0;
      if (flush) begin
        q.delete();
      end else begin
        acc = stb && ((q.size() < 8) || pop);
        drp = stb && !acc;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(int'(result_in));
      end
      m_irq = acc && (result_in >= thr);
      if (drp) begin
        m_ovf = 1;
        m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (clr) begin
        m_ovf = 0;
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    check("level", level, q.size());
    check("valid", data_valid, q.size() != 0);
    if (q.size() != 0) check("data_head", data_out, q[0]);
    check("overflow", ovf, m_ovf);
    check("drop_count", drop_cnt, m_cnt);
    check("irq", irq, m_irq);
  endtask

  task automatic strobe(input int v);
    result_in = 12'(v);
    stb = 1'b1;
    cyc();
    stb = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst = 1'b1; result_in = '0; stb = 1'b0; flush = 1'b0;
    ready = 1'b0; clr = 1'b0; thr = 12'hFFF;
    q.delete(); m_ovf = 0; m_cnt = 0; m_irq = 0;
    idle(2);
    check("reset_data", data_out, 0);
    rst = 1'b0;
    idle(1);

    // Single sample, then pop.
    strobe(12'h64C);
    check("single_valid", data_valid, 1);
    check("single_data", data_out, 12'h64C);
    check("single_level", level, 1);
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    check("single_pop_level", level, 0);
    check("single_pop_valid", data_valid, 0);

    // Five samples, then drain in order.
    strobe(1612); idle(2);
    strobe(15);   idle(2);
    strobe(593);  idle(2);
    strobe(4095); idle(2);
    strobe(0);    idle(1);
    check("five_level", level, 5);
    ready = 1'b1;
    idle(6);
    ready = 1'b0;
    check("five_drained", level, 0);

    // Nine back-to-back samples into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) strobe(i);
    check("nine_level", level, 8);
    check("nine_overflow", ovf, 1);
    check("nine_drops", drop_cnt, 1);
    check("nine_head", data_out, 0);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("clear_overflow", ovf, 0);
    check("clear_drops", drop_cnt, 0);

    // Full FIFO with write and pop in the same cycle.
    ready = 1'b1;
    strobe(100);
    ready = 1'b0;
    check("fullpop_level", level, 8);
    check("fullpop_head", data_out, 1);
    check("fullpop_drops", drop_cnt, 0);
    ready = 1'b1;
    idle(9);
    ready = 1'b0;

    // Threshold interrupt.
    thr = 12'd593;
    strobe(15);
    check("irq_15", irq, 0);
    strobe(593);
    check("irq_593", irq, 1);
    idle(1);
    check("irq_593_end", irq, 0);
    strobe(4095);
    check("irq_4095", irq, 1);
    for (int i = 0; i < 5; i++) strobe(1);
    check("irq_fill_level", level, 8);
    strobe(4095);
    check("irq_dropped", irq, 0);
    check("irq_drop_count", drop_cnt, 1);

    // Drop counter saturation, then a clear colliding with a drop.
    for (int i = 0; i < 260; i++) strobe(i);
    check("drop_saturate", drop_cnt, 255);
    clr = 1'b1;
    strobe(7);
    clr = 1'b0;
    check("clear_vs_drop_ovf", ovf, 1);
    check("clear_vs_drop_cnt", drop_cnt, 1);

    // Flush with a simultaneous strobe.
    ready = 1'b1;
    idle(9);
    ready = 1'b0;
    strobe(11); strobe(22); strobe(33);
    check("preflush_level", level, 3);
    flush = 1'b1;
    strobe(44);
    flush = 1'b0;
    check("flush_level", level, 0);
    check("flush_valid", data_valid, 0);
    check("flush_overflow", ovf, 1);
    check("flush_drops", drop_cnt, 1);

    // Reset during a pending pop.
    strobe(55); strobe(66);
    ready = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ready = 1'b0;
    check("rst_level", level, 0);
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_overflow", ovf, 0);
    check("rst_drops", drop_cnt, 0);
    check("rst_irq", irq, 0);
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
